lsu: RTL and testbench
======================

# lsu

Load/store unit: the initiator side of the data-memory interface. It accepts single-word load/store requests and block-fill requests from the CPU core over a valid/ready handshake and sequences them onto `dmem` (`dmem_addr`, `read_val`, `REDMEM`, `data`). It returns one response per request, and load data is captured from `dmem`. It sits between the core's execute stage and `dmem`, and is the only driver of the `dmem` inputs.

## Interface
- `AW`, default 8: address width; must match `dmem`.
- `DW`, default 8: data width; must match `dmem`.

Ports:
- `clk`  in  1  rising-edge clock, shared with `dmem`.
- `reset_lsu_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  LSU can accept a request; high only in IDLE.
- `req_op`  in  2  00 LOAD, 01 STORE, 10 FILL, 11 illegal.
- `req_addr`  in  AW  target / start address.
- `req_wdata`  in  DW  store / fill value.
- `req_len`  in  AW  FILL word count; ignored otherwise.
- `resp_valid`  out  1  response available; held until taken.
- `resp_ready`  in  1  core accepts response.
- `resp_data`  out  DW  LOAD: read value; STORE/FILL: echoed wdata; illegal: 0.
- `resp_err`  out  1  set only for illegal op.
- `dmem_addr`  out  AW  memory address.
- `read_val`  out  DW  write data to memory.
- `REDMEM`  out  1  1 = write `read_val` at `dmem_addr` on the next rising edge; 0 = read.
- `data`  in  DW  memory read data; valid one cycle after the address is presented with `REDMEM`=0.

## Operation
- FSM states: IDLE, LD_ADDR, LD_CAP, ST, FILL, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch op/addr/wdata/len:
  - LOAD → LD_ADDR
  - STORE → ST
  - FILL with len≠0 → FILL
  - FILL with len=0 → RESP
  - illegal → RESP with `resp_err`=1
- LD_ADDR: drive `dmem_addr`=addr, `REDMEM`=0; go to LD_CAP.
- LD_CAP: hold address, `REDMEM`=0; at the edge, capture `data` into `resp_data`; go to RESP.
- ST: drive addr and wdata with `REDMEM`=1 for exactly one cycle; go to RESP.
- FILL: `REDMEM`=1 each cycle, with `dmem_addr` = start + k (mod 2^AW) for k = 0..len−1.
  - Address wraps 8'hFF → 8'h00.
  - Internal remaining-count decrements once per cycle; exit to RESP after the last write.
- RESP: `resp_valid`=1. When `resp_ready`=1 at an edge, clear `resp_valid`, clear `resp_err`, go to IDLE.
- `REDMEM` is 1 only in ST and FILL, and is never asserted in any other state.
- `req_ready` and `resp_valid` are never high in the same cycle.
- No request queuing. A `req_valid` outside IDLE is ignored; the core must hold it until it is accepted.

## Timing
- Reset values, applied immediately on `reset_lsu_n` low:
  - state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_data`=0
  - `dmem_addr`=0, `read_val`=0, `REDMEM`=0
- Latency, counted from the accept edge E0 to the first cycle `resp_valid`=1:
  - LOAD: 3 cycles (LD_ADDR, LD_CAP, RESP)
  - STORE: 2 cycles
  - FILL with N≠0: N+1 cycles
  - FILL with len=0 or illegal op: 1 cycle
- If `resp_ready` is high in the first RESP cycle, the next request is accepted no earlier than 2 cycles after `resp_valid` rises. There is always one IDLE cycle between requests.
- `dmem`-side outputs are driven from registered state/latched fields and are stable for the whole cycle.
- Reset mid-operation:
  - An in-flight FILL is aborted; words already written stay written.
  - A pending response is dropped.
  - `REDMEM` falls asynchronously with reset, so no partial write occurs after reset assertion.
- `resp_data` and `resp_err` hold their values while `resp_valid`=1 and `resp_ready`=0.

## Structure
- Shared package `lsu_pkg`: the `req_op` encodings (OP_LOAD, OP_STORE, OP_FILL) and the FSM state encoding.
- Single module. The FILL address/count logic is small and stays inline; no sub-module is warranted.
- `AW`/`DW` are passed down from the CPU top alongside the `dmem` instance.

## Test plan
- Reset: assert `reset_lsu_n`=0 mid-FILL → `REDMEM`=0 immediately, `req_ready`=1, all outputs 0; after release, the first LOAD works normally.
- Store then load: STORE addr 8'h00 wdata 8'h55 → `REDMEM`=1 for one cycle with `dmem_addr`=00, `read_val`=55; then LOAD addr 8'h00 → `resp_data`=8'h55, `resp_err`=0, `resp_valid` 3 cycles after accept.
- FILL wrap: FILL addr 8'hFE len 4 wdata 8'hA5 → writes to FE, FF, 00, 01 in 4 consecutive cycles; loads of each address return A5, and address 02 is unchanged.
- Edge ops: FILL len 0 → response next cycle, no `REDMEM` pulse. Op 11 → `resp_err`=1, `resp_data`=0, no memory access.
- Backpressure: hold `resp_ready`=0 for 5 cycles after a LOAD → `resp_valid` and `resp_data` are stable, `req_ready`=0, and a new `req_valid` is ignored until the response is taken.
- Back-to-back: 10 random STORE/LOAD pairs with `resp_ready`=1 → a scoreboard matches every load, and there is exactly one `REDMEM` cycle per store.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit.
// Request opcodes and FSM state encoding.
package lsu_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_FILL  = 2'b10,
    OP_ILL   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_ADDR = 3'd1,
    S_LD_CAP  = 3'd2,
    S_ST      = 3'd3,
    S_FILL    = 3'd4,
    S_RESP    = 3'd5
  } state_e;

endpackage

// File: rtl/lsu.sv
// Load/store unit: initiator side of the data-memory port.
// Single-word LOAD/STORE and block FILL over valid/ready.
module lsu
  import lsu_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_lsu_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [AW-1:0] req_len,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_data,
  output logic          resp_err,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] read_val,
  output logic          REDMEM,
  input  logic [DW-1:0] data
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or negedge reset_lsu_n) begin
    if (!reset_lsu_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = req_len;
          err_d   = 1'b0;
          unique case (req_op)
            OP_LOAD: state_d = S_LD_ADDR;
            OP_STORE: begin
              rdata_d = req_wdata;
              state_d = S_ST;
            end
            OP_FILL: begin
              rdata_d = req_wdata;
              state_d = (req_len != '0) ? S_FILL : S_RESP;
            end
            default: begin
              rdata_d = '0;
              err_d   = 1'b1;
              state_d = S_RESP;
            end
          endcase
        end
      end
      S_LD_ADDR: state_d = S_LD_CAP;
      S_LD_CAP: begin
        rdata_d = data;
        state_d = S_RESP;
      end
      S_ST: state_d = S_RESP;
      S_FILL: begin
        // Address wraps naturally at AW bits.
        addr_d = addr_q + AW'(1);
        cnt_d  = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = rdata_q;
  assign resp_err   = err_q;
  assign dmem_addr  = addr_q;
  assign read_val   = wdata_q;
  assign REDMEM     = (state_q == S_ST) || (state_q == S_FILL);

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu with a behavioural memory
// and a request-level reference model.
module tb_lsu;
  import lsu_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [AW-1:0] req_len;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] read_val;
  logic          REDMEM;
  logic [DW-1:0] data;

  lsu #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset_lsu_n(rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_len    (req_len),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .dmem_addr  (dmem_addr),
    .read_val   (read_val),
    .REDMEM     (REDMEM),
    .data       (data)
  );

  logic [7:0] mem [256];
  logic [7:0] seed_mem [256];
  logic [7:0] ref_mem [256];
  logic       init_mem;
  int         cyc = 0;

  logic [7:0] wr_a [$];
  logic [7:0] wr_d [$];
  int         wr_c [$];

  // Synchronous-read memory; one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed_mem[i];
    end else begin
      if (REDMEM) mem[dmem_addr] <= read_val;
      data <= mem[dmem_addr];
    end
  end

  always @(posedge clk) begin
    if (REDMEM) begin
      wr_a.push_back(dmem_addr);
      wr_d.push_back(read_val);
      wr_c.push_back(cyc);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_log();
    wr_a.delete();
    wr_d.delete();
    wr_c.delete();
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] w, input logic [7:0] l,
                       output int e0);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = w;
    req_len   = l;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", req_ready, 1);
    @(posedge clk);
    #1;
    e0 = cyc;
    req_valid = 1'b0;
  endtask

  task automatic get_resp(input int e0, output logic [7:0] d,
                          output logic err, output int lat);
    int n = 0;
    @(negedge clk);
    while (!resp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - e0 + 1;
    d   = resp_data;
    err = resp_err;
    chk("resp_valid", resp_valid, 1);
    chk("ready_excl", req_ready, 0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("resp_clear", {resp_valid, resp_err}, 0);
  endtask

  // Issue one request and check it against the reference model.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] w, input logic [7:0] l);
    int e0, lat, exp_lat, nw;
    logic [7:0] d, exp_d;
    logic err;
    clr_log();
    case (op)
      OP_LOAD:  begin exp_lat = 3; exp_d = ref_mem[a]; nw = 0; end
      OP_STORE: begin exp_lat = 2; exp_d = w; nw = 1; end
      OP_FILL:  begin
        exp_lat = (l == 0) ? 1 : int'(l) + 1;
        exp_d = w;
        nw = int'(l);
      end
      default:  begin exp_lat = 1; exp_d = 8'h00; nw = 0; end
    endcase
    issue(op, a, w, l, e0);
    get_resp(e0, d, err, lat);
    chk($sformatf("lat_op%0d_a%02h", op, a), lat, exp_lat);
    chk($sformatf("data_op%0d_a%02h", op, a), d, exp_d);
    chk($sformatf("err_op%0d", op), err, (op == OP_ILL));
    chk($sformatf("nwr_op%0d_a%02h", op, a), wr_a.size(), nw);
    for (int k = 0; k < nw && k < wr_a.size(); k++) begin
      chk($sformatf("wr_addr_%0d", k), wr_a[k], 8'(a + k));
      chk($sformatf("wr_data_%0d", k), wr_d[k], w);
      chk($sformatf("wr_cyc_%0d", k), wr_c[k] - wr_c[0], k);
    end
    for (int k = 0; k < nw; k++) ref_mem[8'(a + k)] = w;
  endtask

  initial begin
    int e0, lat, n;
    logic [7:0] d, hold_d, a, w, la;
    logic err;
    logic [7:0] probe [5];

    for (int i = 0; i < 256; i++) begin
      seed_mem[i] = 8'($urandom);
      ref_mem[i]  = seed_mem[i];
    end
    rst_n = 1'b0;
    init_mem = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    req_len = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp", {resp_valid, resp_err, resp_data}, 0);
    chk("rst_dmem", {REDMEM, dmem_addr, read_val}, 0);
    init_mem = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Store then load at address 0.
    do_op(OP_STORE, 8'h00, 8'h55, 8'h00);
    do_op(OP_LOAD, 8'h00, 8'h00, 8'h00);
    chk("ld00_model", ref_mem[0], 8'h55);

    // Fill across the address wrap.
    do_op(OP_FILL, 8'hFE, 8'hA5, 8'd4);
    probe = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    for (int i = 0; i < 5; i++) do_op(OP_LOAD, probe[i], 8'h00, 8'h00);

    // Edge ops.
    do_op(OP_FILL, 8'h40, 8'h9C, 8'd0);
    do_op(OP_ILL, 8'h41, 8'h77, 8'd3);
    do_op(OP_LOAD, 8'h40, 8'h00, 8'h00);

    // Backpressure with a competing request held high.
    clr_log();
    issue(OP_LOAD, 8'h02, 8'h00, 8'h00, e0);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    hold_d = resp_data;
    chk("bp_first", resp_data, ref_mem[2]);
    req_valid = 1'b1;
    req_op = OP_STORE;
    req_addr = 8'h02;
    req_wdata = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_%0d", i), resp_valid, 1);
      chk($sformatf("bp_data_%0d", i), resp_data, hold_d);
      chk($sformatf("bp_ready_%0d", i), req_ready, 0);
      chk($sformatf("bp_wr_%0d", i), REDMEM, 0);
      @(negedge clk);
    end
    chk("bp_nowrite", wr_a.size(), 0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle", req_ready, 1);
    @(posedge clk);
    #1;
    e0 = cyc;
    req_valid = 1'b0;
    get_resp(e0, d, err, lat);
    chk("bp_st_lat", lat, 2);
    chk("bp_st_data", d, 8'h3C);
    chk("bp_st_nwr", wr_a.size(), 1);
    ref_mem[2] = 8'h3C;
    do_op(OP_LOAD, 8'h02, 8'h00, 8'h00);

    // Random store/load pairs.
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom);
      w = 8'($urandom);
      la = (i % 2 == 0) ? a : 8'($urandom);
      do_op(OP_STORE, a, w, 8'h00);
      do_op(OP_LOAD, la, 8'h00, 8'h00);
    end

    // Reset in the middle of a long fill.
    clr_log();
    issue(OP_FILL, 8'h10, 8'h77, 8'd20, e0);
    repeat (6) @(negedge clk);
    chk("mid_fill_wr", REDMEM, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_redmem", REDMEM, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_resp", {resp_valid, resp_err, resp_data}, 0);
    chk("arst_dmem", {dmem_addr, read_val}, 0);
    n = wr_a.size();
    chk("arst_words", n, 5);
    for (int k = 0; k < n; k++) ref_mem[8'(8'h10 + k)] = 8'h77;
    repeat (2) @(negedge clk);
    chk("arst_hold", REDMEM, 0);
    rst_n = 1'b1;
    do_op(OP_LOAD, 8'h14, 8'h00, 8'h00);
    do_op(OP_LOAD, 8'h15, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
